// File: rtl/deparser_emit_if.sv
// Header capture, payload and output stream signals of the deparser emit stage.
// The slave modport is the emit stage itself; master is whatever drives and consumes it.
interface deparser_emit_if #(
   parameter int unsigned HEAD_WIDTH = 512,
   parameter int unsigned TAG_WIDTH  = 8,
   parameter int unsigned DATA_WIDTH = 128,
   parameter int unsigned HLEN_WIDTH = 7
);
   localparam int unsigned LenW = $clog2(DATA_WIDTH / 8) + 1;

   logic [HEAD_WIDTH+TAG_WIDTH-1:0] i_head;
   logic [HLEN_WIDTH-1:0]           i_head_len;
   logic                            i_pld_valid;
   logic                            o_pld_ready;
   logic [DATA_WIDTH-1:0]           i_pld_data;
   logic                            i_pld_last;
   logic [LenW-1:0]                 i_pld_len;
   logic                            o_valid;
   logic                            i_ready;
   logic [DATA_WIDTH-1:0]           o_data;
   logic                            o_last;
   logic [LenW-1:0]                 o_len;
   logic [TAG_WIDTH-2:0]            o_pkt_id;
   logic                            o_head_drop;

   modport slave (
      input  i_head, i_head_len, i_pld_valid, i_pld_data, i_pld_last, i_pld_len, i_ready,
      output o_pld_ready, o_valid, o_data, o_last, o_len, o_pkt_id, o_head_drop
   );

   modport master (
      output i_head, i_head_len, i_pld_valid, i_pld_data, i_pld_last, i_pld_len, i_ready,
      input  o_pld_ready, o_valid, o_data, o_last, o_len, o_pkt_id, o_head_drop
   );
endinterface

// File: rtl/deparser_emit.sv
// Deparser emit stage: queues rebuilt headers, serialises each onto the byte stream and
// appends the packet payload realigned behind the header's trailing partial beat.
module deparser_emit #(
   parameter int unsigned HEAD_WIDTH = 512,
   parameter int unsigned TAG_WIDTH  = 8,
   parameter int unsigned DATA_WIDTH = 128,
   parameter int unsigned HLEN_WIDTH = 7,
   parameter int unsigned QDEPTH     = 2
) (
   input logic           i_clk,
   input logic           i_rst,
   deparser_emit_if.slave bus
);
   localparam int unsigned NB = DATA_WIDTH / 8;
   localparam int unsigned HB = HEAD_WIDTH / 8;
   localparam int unsigned OW = $clog2(NB);
   localparam int unsigned CW = OW + 1;
   localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

   typedef enum logic [1:0] {StIdle, StHead, StPld, StFlush} state_e;

   function automatic logic [DATA_WIDTH-1:0] keep_bytes(input logic [DATA_WIDTH-1:0] d,
                                                        input logic [CW-1:0] n);
      if (n >= CW'(NB)) return d;
      return d & ~({DATA_WIDTH{1'b1}} >> {n, 3'b000});
   endfunction

   logic [HEAD_WIDTH-1:0]  qh_q [QDEPTH];
   logic [HEAD_WIDTH-1:0]  qh_d [QDEPTH];
   logic [HLEN_WIDTH-1:0]  ql_q [QDEPTH];
   logic [HLEN_WIDTH-1:0]  ql_d [QDEPTH];
   logic [TAG_WIDTH-2:0]   qi_q [QDEPTH];
   logic [TAG_WIDTH-2:0]   qi_d [QDEPTH];
   logic [PW-1:0]          wr_q, wr_d, rd_q, rd_d;
   logic [PW:0]            cnt_q, cnt_d;
   logic                   drop_q, drop_d;

   state_e                 state_q, state_d;
   logic [HEAD_WIDTH-1:0]  hdr_q, hdr_d;
   logic [HLEN_WIDTH-1:0]  nb_q, nb_d, hidx_q, hidx_d;
   logic [OW-1:0]          off_q, off_d;
   logic [DATA_WIDTH-1:0]  res_q, res_d;
   logic [CW-1:0]          flen_q, flen_d;
   logic [TAG_WIDTH-2:0]   pid_q, pid_d;
   logic                   ov_q, ov_d, olast_q, olast_d;
   logic [DATA_WIDTH-1:0]  od_q, od_d;
   logic [CW-1:0]          olen_q, olen_d;

   logic                    tag_valid, full, pop, push, out_free, pld_rdy;
   logic [HLEN_WIDTH-1:0]   in_len, e_len, e_nb;
   logic [HEAD_WIDTH-1:0]   in_hdr;
   logic [CW-1:0]           pld_k, sh_bytes, total;
   logic [DATA_WIDTH-1:0]   pld_m;
   logic [2*DATA_WIDTH-1:0] merged;

   assign tag_valid = bus.i_head[TAG_WIDTH-1];
   assign in_len    = (bus.i_head_len > HLEN_WIDTH'(HB)) ? HLEN_WIDTH'(HB) : bus.i_head_len;
   assign in_hdr    = bus.i_head[HEAD_WIDTH+TAG_WIDTH-1 -: HEAD_WIDTH] &
                      ~({HEAD_WIDTH{1'b1}} >> {in_len, 3'b000});
   assign full      = (cnt_q == (PW+1)'(QDEPTH));
   // Pop only when downstream is ready, so a stalled beat never sees its packet id change.
   assign pop       = (state_q == StIdle) && (cnt_q != '0) && bus.i_ready;
   assign push      = tag_valid && (!full || pop);
   assign e_len     = ql_q[rd_q];
   assign e_nb      = e_len >> OW;
   assign out_free  = !ov_q || bus.i_ready;

   // Residue sits MSB-aligned in res_q; payload slides in right behind it.
   assign pld_k    = bus.i_pld_last ? bus.i_pld_len : CW'(NB);
   assign pld_m    = keep_bytes(bus.i_pld_data, pld_k);
   assign sh_bytes = CW'(NB) - CW'(off_q);
   assign merged   = {res_q, {DATA_WIDTH{1'b0}}} |
                     ({{DATA_WIDTH{1'b0}}, pld_m} << {sh_bytes, 3'b000});
   assign total    = CW'(off_q) + pld_k;

   always_comb begin
      qh_d   = qh_q;
      ql_d   = ql_q;
      qi_d   = qi_q;
      wr_d   = wr_q;
      rd_d   = rd_q;
      cnt_d  = cnt_q;
      drop_d = tag_valid && full && !pop;
      if (push) begin
         qh_d[wr_q] = in_hdr;
         ql_d[wr_q] = in_len;
         qi_d[wr_q] = bus.i_head[TAG_WIDTH-2:0];
         wr_d       = wr_q + 1'b1;
      end
      if (pop) rd_d = rd_q + 1'b1;
      if (push && !pop) cnt_d = cnt_q + 1'b1;
      else if (pop && !push) cnt_d = cnt_q - 1'b1;
   end

   always_comb begin
      state_d = state_q;
      hdr_d   = hdr_q;
      nb_d    = nb_q;
      hidx_d  = hidx_q;
      off_d   = off_q;
      res_d   = res_q;
      flen_d  = flen_q;
      pid_d   = pid_q;
      ov_d    = ov_q && !bus.i_ready;
      od_d    = od_q;
      olast_d = olast_q;
      olen_d  = olen_q;
      pld_rdy = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (pop) begin
               hdr_d   = qh_q[rd_q];
               nb_d    = e_nb;
               hidx_d  = '0;
               off_d   = e_len[OW-1:0];
               pid_d   = qi_q[rd_q];
               res_d   = qh_q[rd_q][HEAD_WIDTH-1 -: DATA_WIDTH];
               state_d = (e_nb != '0) ? StHead : StPld;
            end
         end
         StHead: begin
            if (out_free) begin
               ov_d    = 1'b1;
               od_d    = hdr_q[HEAD_WIDTH-1 -: DATA_WIDTH];
               olen_d  = CW'(NB);
               olast_d = 1'b0;
               hdr_d   = hdr_q << DATA_WIDTH;
               hidx_d  = hidx_q + 1'b1;
               if (hidx_q == nb_q - 1'b1) begin
                  res_d   = hdr_q[HEAD_WIDTH-DATA_WIDTH-1 -: DATA_WIDTH];
                  state_d = StPld;
               end
            end
         end
         StPld: begin
            pld_rdy = out_free;
            if (out_free && bus.i_pld_valid) begin
               ov_d  = 1'b1;
               od_d  = merged[2*DATA_WIDTH-1 -: DATA_WIDTH];
               res_d = merged[DATA_WIDTH-1:0];
               if (bus.i_pld_last && total <= CW'(NB)) begin
                  olen_d  = total;
                  olast_d = 1'b1;
                  state_d = StIdle;
               end else begin
                  olen_d  = CW'(NB);
                  olast_d = 1'b0;
                  if (bus.i_pld_last) begin
                     flen_d  = total - CW'(NB);
                     state_d = StFlush;
                  end
               end
            end
         end
         StFlush: begin
            if (out_free) begin
               ov_d    = 1'b1;
               od_d    = res_q;
               olen_d  = flen_q;
               olast_d = 1'b1;
               res_d   = '0;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < QDEPTH; i++) begin
            qh_q[i] <= '0;
            ql_q[i] <= '0;
            qi_q[i] <= '0;
         end
         wr_q    <= '0;
         rd_q    <= '0;
         cnt_q   <= '0;
         drop_q  <= 1'b0;
         state_q <= StIdle;
         hdr_q   <= '0;
         nb_q    <= '0;
         hidx_q  <= '0;
         off_q   <= '0;
         res_q   <= '0;
         flen_q  <= '0;
         pid_q   <= '0;
         ov_q    <= 1'b0;
         od_q    <= '0;
         olast_q <= 1'b0;
         olen_q  <= '0;
      end else begin
         qh_q    <= qh_d;
         ql_q    <= ql_d;
         qi_q    <= qi_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         cnt_q   <= cnt_d;
         drop_q  <= drop_d;
         state_q <= state_d;
         hdr_q   <= hdr_d;
         nb_q    <= nb_d;
         hidx_q  <= hidx_d;
         off_q   <= off_d;
         res_q   <= res_d;
         flen_q  <= flen_d;
         pid_q   <= pid_d;
         ov_q    <= ov_d;
         od_q    <= od_d;
         olast_q <= olast_d;
         olen_q  <= olen_d;
      end
   end

   assign bus.o_pld_ready = pld_rdy;
   assign bus.o_valid     = ov_q;
   assign bus.o_data      = od_q;
   assign bus.o_last      = olast_q;
   assign bus.o_len       = olen_q;
   assign bus.o_pkt_id    = pid_q;
   assign bus.o_head_drop = drop_q;
endmodule

// File: tb/tb_deparser_emit.sv
// Bench for deparser_emit: a byte-stream model of header-then-payload packets predicts every
// output beat; directed scenarios cover alignment, flush, backpressure, overflow and reset.
module tb_deparser_emit;
   localparam int HW = 512;
   localparam int TW = 8;
   localparam int DW = 128;
   localparam int LW = 7;
   localparam int QD = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   deparser_emit_if #(.HEAD_WIDTH(HW), .TAG_WIDTH(TW), .DATA_WIDTH(DW), .HLEN_WIDTH(LW)) bus ();

   deparser_emit #(
      .HEAD_WIDTH(HW), .TAG_WIDTH(TW), .DATA_WIDTH(DW), .HLEN_WIDTH(LW), .QDEPTH(QD)
   ) u_dut (
      .i_clk(clk),
      .i_rst(rst),
      .bus  (bus)
   );

   typedef struct packed {
      logic [127:0] data;
      logic [4:0]   len;
      logic         last;
      logic [6:0]   id;
   } beat_t;

   beat_t exp_q[$];
   beat_t got_q[$];
   int    n_chk = 0;
   int    n_fail = 0;
   int    drop_cnt = 0;
   bit    rdy_bp = 1'b0;
   bit    rdy_val = 1'b1;
   int    bp_phase = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
      n_chk++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, want);
      end
   endtask

   function automatic logic [7:0] hb(input int id, input int i);
      return 8'(id * 37 + i * 5 + 3);
   endfunction

   function automatic logic [7:0] pb(input int base, input int j);
      return 8'(base + j);
   endfunction

   function automatic beat_t gb(input int i);
      if (i < got_q.size()) return got_q[i];
      return '0;
   endfunction

   // Expected stream: clamped header bytes followed by payload bytes, cut into 16-byte beats.
   task automatic model_pkt(input int id, input int hlen, input int pbase, input int plen);
      logic [7:0] s[$];
      int hl;
      hl = (hlen > 64) ? 64 : hlen;
      for (int i = 0; i < hl; i++) s.push_back(hb(id, i));
      for (int j = 0; j < plen; j++) s.push_back(pb(pbase, j));
      for (int i = 0; i < s.size(); i += 16) begin
         beat_t b;
         int    n;
         n      = (s.size() - i >= 16) ? 16 : s.size() - i;
         b      = '0;
         b.len  = 5'(n);
         b.last = (i + 16 >= s.size());
         b.id   = 7'(id);
         for (int j = 0; j < n; j++) b.data[127-8*j -: 8] = s[i+j];
         exp_q.push_back(b);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_head(input int id, input int len);
      logic [HW+TW-1:0] h;
      int hl;
      hl = (len > 64) ? 64 : len;
      h  = '0;
      for (int i = 0; i < 64; i++) h[HW+TW-1-8*i -: 8] = (i < hl) ? hb(id, i) : 8'hEE;
      h[7:0]         = {1'b1, 7'(id)};
      bus.i_head     = h;
      bus.i_head_len = 7'(len);
      cyc(1);
      bus.i_head     = '0;
      bus.i_head_len = '0;
   endtask

   task automatic send_pld(input int pbase, input int plen);
      int nbt;
      nbt = (plen + 15) / 16;
      for (int b = 0; b < nbt; b++) begin
         logic [127:0] d;
         int t;
         for (int j = 0; j < 16; j++)
            d[127-8*j -: 8] = (b * 16 + j < plen) ? pb(pbase, b * 16 + j) : 8'hDD;
         bus.i_pld_valid = 1'b1;
         bus.i_pld_data  = d;
         bus.i_pld_last  = (b == nbt - 1);
         bus.i_pld_len   = (b == nbt - 1) ? 5'(plen - b * 16) : 5'd16;
         t = 0;
         @(negedge clk);
         while (!bus.o_pld_ready && t < 500) begin
            @(negedge clk);
            t++;
         end
         if (t >= 500) begin
            n_chk++;
            n_fail++;
            $display("FAIL pld_accept_timeout: got no o_pld_ready expected acceptance");
            bus.i_pld_valid = 1'b0;
            return;
         end
         cyc(1);
      end
      bus.i_pld_valid = 1'b0;
      bus.i_pld_data  = '0;
      bus.i_pld_last  = 1'b0;
      bus.i_pld_len   = '0;
   endtask

   task automatic drain(input string name);
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 1000) begin
         @(posedge clk);
         t++;
      end
      #1;
      chk(name, exp_q.size(), 0);
   endtask

   always @(posedge clk) begin
      #1;
      if (rdy_bp) begin
         bus.i_ready = (bp_phase % 3 == 0);
         bp_phase++;
      end else begin
         bus.i_ready = rdy_val;
      end
   end

   // Compare process: every transferred beat against the model, plus hold-during-stall rules.
   bit    stall_prev = 1'b0;
   beat_t held, cur, ebeat;
   always @(negedge clk) begin
      if (rst) begin
         stall_prev = 1'b0;
      end else begin
         cur.data = bus.o_data;
         cur.len  = bus.o_len;
         cur.last = bus.o_last;
         cur.id   = bus.o_pkt_id;
         if (bus.o_head_drop) drop_cnt++;
         if (stall_prev) begin
            chk("hold_valid", bus.o_valid, 1);
            chk("hold_beat", cur, held);
         end
         if (bus.o_valid && !bus.i_ready) chk("pld_ready_stalled", bus.o_pld_ready, 0);
         if (bus.o_valid && bus.i_ready) begin
            got_q.push_back(cur);
            if (exp_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_beat: got %h expected no beat", bus.o_data);
            end else begin
               ebeat = exp_q.pop_front();
               chk("beat_data", cur.data, ebeat.data);
               chk("beat_len", cur.len, ebeat.len);
               chk("beat_last", cur.last, ebeat.last);
               chk("beat_id", cur.id, ebeat.id);
            end
         end
         stall_prev = bus.o_valid && !bus.i_ready;
         held       = cur;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion expected finish");
      $fatal(1);
   end

   initial begin
      int g0, d0;
      rst             = 1'b1;
      bus.i_head      = '0;
      bus.i_head_len  = '0;
      bus.i_pld_valid = 1'b0;
      bus.i_pld_data  = '0;
      bus.i_pld_last  = 1'b0;
      bus.i_pld_len   = '0;
      cyc(2);
      chk("rst_valid", bus.o_valid, 0);
      chk("rst_pld_ready", bus.o_pld_ready, 0);
      chk("rst_last", bus.o_last, 0);
      chk("rst_drop", bus.o_head_drop, 0);
      chk("rst_data", bus.o_data, 0);
      chk("rst_len", bus.o_len, 0);
      chk("rst_id", bus.o_pkt_id, 0);
      rst = 1'b0;
      cyc(2);

      // Aligned header, two payload beats.
      g0 = got_q.size();
      send_head(5, 32);
      model_pkt(5, 32, 8'h10, 32);
      send_pld(8'h10, 32);
      drain("t1_drain");
      chk("t1_count", got_q.size() - g0, 4);
      chk("t1_last_first", gb(g0).last, 0);
      chk("t1_last_final", gb(g0 + 3).last, 1);
      chk("t1_id", gb(g0 + 3).id, 5);
      chk("t1_pld_unshifted", gb(g0 + 2).data, 128'h101112131415161718191A1B1C1D1E1F);

      // Unaligned header with flush beat.
      g0 = got_q.size();
      send_head(6, 20);
      model_pkt(6, 20, 0, 16);
      send_pld(0, 16);
      drain("t2_drain");
      chk("t2_count", got_q.size() - g0, 3);
      chk("t2_merge_tail", gb(g0 + 1).data[95:0], 96'h000102030405060708090A0B);
      chk("t2_flush_data", gb(g0 + 2).data, 128'h0C0D0E0F000000000000000000000000);
      chk("t2_flush_len", gb(g0 + 2).len, 4);
      chk("t2_flush_last", gb(g0 + 2).last, 1);

      // Merge without flush, then payload-only passthrough.
      g0 = got_q.size();
      send_head(7, 14);
      model_pkt(7, 14, 8'h30, 2);
      send_pld(8'h30, 2);
      drain("t3a_drain");
      chk("t3a_count", got_q.size() - g0, 1);
      chk("t3a_len", gb(g0).len, 16);
      chk("t3a_tail", gb(g0).data[15:0], 16'h3031);
      g0 = got_q.size();
      send_head(8, 0);
      model_pkt(8, 0, 8'h40, 20);
      send_pld(8'h40, 20);
      drain("t3b_drain");
      chk("t3b_beat0", gb(g0).data, 128'h404142434445464748494A4B4C4D4E4F);
      chk("t3b_beat1", gb(g0 + 1).data, 128'h50515253000000000000000000000000);
      chk("t3b_len1", gb(g0 + 1).len, 4);

      // Unaligned packet under a 1,0,0 ready pattern.
      g0       = got_q.size();
      bp_phase = 0;
      rdy_bp   = 1'b1;
      send_head(6, 20);
      model_pkt(6, 20, 0, 16);
      send_pld(0, 16);
      drain("t4_drain");
      rdy_bp = 1'b0;
      cyc(2);
      chk("t4_flush_data", gb(g0 + 2).data, 128'h0C0D0E0F000000000000000000000000);

      // Overflow: three headers back to back with downstream stalled.
      rdy_val = 1'b0;
      cyc(3);
      g0 = got_q.size();
      d0 = drop_cnt;
      send_head(1, 16);
      send_head(2, 16);
      send_head(3, 16);
      model_pkt(1, 16, 8'h60, 16);
      model_pkt(2, 16, 8'h70, 16);
      cyc(3);
      chk("t5_drop_count", drop_cnt - d0, 1);
      chk("t5_held_back", got_q.size() - g0, 0);
      rdy_val = 1'b1;
      send_pld(8'h60, 16);
      send_pld(8'h70, 16);
      drain("t5_drain");
      cyc(5);
      chk("t5_count", got_q.size() - g0, 4);
      chk("t5_id_first", gb(g0).id, 1);
      chk("t5_id_second", gb(g0 + 2).id, 2);

      // Reset mid-payload with a second header queued.
      g0 = got_q.size();
      send_head(9, 20);
      send_head(10, 16);
      model_pkt(9, 20, 8'hA0, 16);
      for (int t = 0; t < 100 && got_q.size() == g0; t++) cyc(1);
      chk("t6_head_beat_seen", got_q.size() - g0, 1);
      cyc(1);
      rst = 1'b1;
      #1;
      exp_q.delete();
      chk("t6_rst_valid", bus.o_valid, 0);
      chk("t6_rst_pld_ready", bus.o_pld_ready, 0);
      chk("t6_rst_last", bus.o_last, 0);
      chk("t6_rst_data", bus.o_data, 0);
      chk("t6_rst_len", bus.o_len, 0);
      chk("t6_rst_id", bus.o_pkt_id, 0);
      cyc(2);
      rst = 1'b0;
      g0  = got_q.size();
      cyc(20);
      chk("t6_quiet_after_reset", got_q.size() - g0, 0);

      // Over-length header is clamped to 64 bytes.
      send_head(11, 100);
      model_pkt(11, 100, 8'h80, 33);
      send_pld(8'h80, 33);
      drain("t6_drain");
      cyc(2);
      chk("t6_count", got_q.size() - g0, 7);
      chk("t6_last_len", gb(g0 + 6).len, 1);
      chk("t6_last_id", gb(g0 + 6).id, 11);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
